// File: rtl/circuito_exp6_pkg.sv
// rtl/circuito_exp6_pkg.sv - shared state codes and constants for the memory game
package circuito_exp6_pkg;

   typedef enum logic [3:0] {
      ST_INICIAL        = 4'h0,
      ST_PREPARACAO     = 4'h1,
      ST_EXIBE          = 4'h2,
      ST_ESPERA         = 4'h3,
      ST_REGISTRA       = 4'h4,
      ST_COMPARA        = 4'h5,
      ST_ESPERA_NOVA    = 4'h6,
      ST_ESCREVE        = 4'h7,
      ST_PROXIMA_RODADA = 4'h8,
      ST_FIM_ACERTO     = 4'hA,
      ST_FIM_TIMEOUT    = 4'hD,
      ST_FIM_ERRO       = 4'hE
   } estado_t;

   localparam int         SHOW_CYCLES_DEF    = 2000;
   localparam int         TIMEOUT_CYCLES_DEF = 5000;
   localparam logic [3:0] LIMIT_DEMO         = 4'd3;
   localparam logic [3:0] LIMIT_FULL         = 4'd15;
   localparam logic [3:0] RAM0_INIT          = 4'b0001;

   function automatic logic [1:0] botao_idx(input logic [3:0] b);
      case (b)
         4'b0010: botao_idx = 2'd1;
         4'b0100: botao_idx = 2'd2;
         4'b1000: botao_idx = 2'd3;
         default: botao_idx = 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/circuito_exp6_if.sv
// rtl/circuito_exp6_if.sv - board-side buttons, switches, LEDs and debug displays
interface circuito_exp6_if;
   logic       jogar;
   logic [3:0] botoes;
   logic [1:0] configuracao;
   logic       ganhou;
   logic       perdeu;
   logic       pronto;
   logic       timeout;
   logic [2:0] leds;
   logic       db_igual;
   logic [6:0] db_contagem;
   logic [6:0] db_memoria;
   logic [6:0] db_estado;
   logic [6:0] db_jogadafeita;
   logic       db_clock;
   logic       db_iniciar;
   logic       db_tem_jogada;
   logic       db_timeout;
   logic       db_fimRodada;
   logic       db_zeraCL;

   modport master (
      output jogar, botoes, configuracao,
      input  ganhou, perdeu, pronto, timeout, leds, db_igual,
             db_contagem, db_memoria, db_estado, db_jogadafeita,
             db_clock, db_iniciar, db_tem_jogada, db_timeout, db_fimRodada, db_zeraCL
   );

   modport slave (
      input  jogar, botoes, configuracao,
      output ganhou, perdeu, pronto, timeout, leds, db_igual,
             db_contagem, db_memoria, db_estado, db_jogadafeita,
             db_clock, db_iniciar, db_tem_jogada, db_timeout, db_fimRodada, db_zeraCL
   );
endinterface

// File: rtl/circuito_exp6_hexa7seg.sv
// rtl/circuito_exp6_hexa7seg.sv - hex digit to active-low gfedcba seven-segment pattern
module hexa7seg (
   input  logic [3:0] hexa,
   output logic [6:0] sseg
);
   always_comb begin
      sseg = 7'b1111111;
      case (hexa)
         4'h0: sseg = 7'b1000000;
         4'h1: sseg = 7'b1111001;
         4'h2: sseg = 7'b0100100;
         4'h3: sseg = 7'b0110000;
         4'h4: sseg = 7'b0011001;
         4'h5: sseg = 7'b0010010;
         4'h6: sseg = 7'b0000010;
         4'h7: sseg = 7'b1111000;
         4'h8: sseg = 7'b0000000;
         4'h9: sseg = 7'b0010000;
         4'hA: sseg = 7'b0001000;
         4'hB: sseg = 7'b0000011;
         4'hC: sseg = 7'b1000110;
         4'hD: sseg = 7'b0100001;
         4'hE: sseg = 7'b0000110;
         4'hF: sseg = 7'b0001110;
         default: sseg = 7'b1111111;
      endcase
   end
endmodule

// File: rtl/circuito_exp6_top.sv
// rtl/circuito_exp6_top.sv - memory-sequence game: FSM, sequence RAM, counters, timers, debug
module circuito_exp6_top
   import circuito_exp6_pkg::*;
#(
   parameter int SHOW_CYCLES    = SHOW_CYCLES_DEF,
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
   input  logic           clock,
   input  logic           reset,
   circuito_exp6_if.slave io
);
   localparam int TMR_W = 16;

   estado_t          state_q, state_d;
   logic [TMR_W-1:0] tmr_q, tmr_d;
   logic [3:0]       addr_q, addr_d;
   logic [3:0]       limit_q, limit_d;
   logic [3:0]       jogada_q, jogada_d;
   logic             modo_q, modo_d;
   logic             tmo_en_q, tmo_en_d;
   logic             tem_q;

   logic [3:0] ram_mem [16];
   logic [3:0] ram_out;
   logic [3:0] limit_final;
   logic       tem_jogada, jog_edge, igual, show_done, tmo_hit, esperando;

   assign tem_jogada  = |io.botoes;
   assign jog_edge    = tem_jogada & ~tem_q;
   // Address 0 is never written, so its power-up word is a constant.
   assign ram_out     = (addr_q == 4'd0) ? RAM0_INIT : ram_mem[addr_q];
   assign igual       = (jogada_q == ram_out);
   assign limit_final = modo_q ? LIMIT_DEMO : LIMIT_FULL;
   assign esperando   = (state_q == ST_ESPERA) || (state_q == ST_ESPERA_NOVA);
   assign show_done   = (tmr_q == TMR_W'(SHOW_CYCLES - 1));
   assign tmo_hit     = tmo_en_q && esperando && !jog_edge &&
                        (tmr_q == TMR_W'(TIMEOUT_CYCLES - 1));

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      limit_d  = limit_q;
      jogada_d = jogada_q;
      modo_d   = modo_q;
      tmo_en_d = tmo_en_q;
      case (state_q)
         ST_INICIAL: if (io.jogar) state_d = ST_PREPARACAO;
         ST_PREPARACAO: begin
            modo_d   = io.configuracao[0];
            tmo_en_d = io.configuracao[1];
            addr_d   = 4'd0;
            limit_d  = 4'd0;
            state_d  = ST_EXIBE;
         end
         ST_EXIBE: if (show_done) state_d = ST_ESPERA;
         ST_ESPERA, ST_ESPERA_NOVA: begin
            if (jog_edge) begin
               jogada_d = io.botoes;
               state_d  = (state_q == ST_ESPERA) ? ST_REGISTRA : ST_ESCREVE;
            end else if (tmo_hit) begin
               state_d = ST_FIM_TIMEOUT;
            end
         end
         ST_REGISTRA: state_d = ST_COMPARA;
         ST_COMPARA: begin
            if (!igual) begin
               state_d = ST_FIM_ERRO;
            end else if (addr_q < limit_q) begin
               addr_d  = addr_q + 4'd1;
               state_d = ST_ESPERA;
            end else if (limit_q == limit_final) begin
               state_d = ST_FIM_ACERTO;
            end else begin
               state_d = ST_ESPERA_NOVA;
            end
         end
         ST_ESCREVE: state_d = ST_PROXIMA_RODADA;
         ST_PROXIMA_RODADA: begin
            limit_d = limit_q + 4'd1;
            addr_d  = 4'd0;
            state_d = ST_ESPERA;
         end
         ST_FIM_ACERTO, ST_FIM_ERRO, ST_FIM_TIMEOUT:
            if (io.jogar) state_d = ST_PREPARACAO;
         default: state_d = ST_INICIAL;
      endcase

      // One timer serves both the display window and the play timeout; any state change clears it.
      tmr_d = '0;
      if ((state_d == state_q) && ((state_q == ST_EXIBE) || esperando))
         tmr_d = tmr_q + TMR_W'(1);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= ST_INICIAL;
         tmr_q    <= '0;
         addr_q   <= 4'd0;
         limit_q  <= 4'd0;
         jogada_q <= 4'd0;
         modo_q   <= 1'b0;
         tmo_en_q <= 1'b0;
         tem_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         tmr_q    <= tmr_d;
         addr_q   <= addr_d;
         limit_q  <= limit_d;
         jogada_q <= jogada_d;
         modo_q   <= modo_d;
         tmo_en_q <= tmo_en_d;
         tem_q    <= tem_jogada;
      end
   end

   always_ff @(posedge clock) begin
      if (state_q == ST_ESCREVE) ram_mem[limit_q + 4'd1] <= jogada_q;
   end

   assign io.ganhou        = (state_q == ST_FIM_ACERTO);
   assign io.perdeu        = (state_q == ST_FIM_ERRO) || (state_q == ST_FIM_TIMEOUT);
   assign io.timeout       = (state_q == ST_FIM_TIMEOUT);
   assign io.pronto        = io.ganhou || io.perdeu;
   assign io.leds          = (state_q == ST_EXIBE) ? {1'b1, botao_idx(ram_out)} : 3'b000;
   assign io.db_igual      = igual;
   assign io.db_clock      = clock;
   assign io.db_iniciar    = io.jogar;
   assign io.db_tem_jogada = tem_jogada;
   assign io.db_timeout    = tmo_hit;
   assign io.db_fimRodada  = (state_q == ST_COMPARA) && (addr_q == limit_q);
   assign io.db_zeraCL     = (state_q == ST_PREPARACAO);

   hexa7seg u_hex_contagem (.hexa(addr_q),   .sseg(io.db_contagem));
   hexa7seg u_hex_memoria  (.hexa(ram_out),  .sseg(io.db_memoria));
   hexa7seg u_hex_estado   (.hexa(state_q),  .sseg(io.db_estado));
   hexa7seg u_hex_jogada   (.hexa(jogada_q), .sseg(io.db_jogadafeita));
endmodule

// File: tb/tb_circuito_exp6_top.sv
// tb/tb_circuito_exp6_top.sv - directed self-checking bench for the memory game top
module tb_circuito_exp6_top;
   logic clock = 1'b0;
   logic reset;

   circuito_exp6_if bus ();

   circuito_exp6_top dut (
      .clock (clock),
      .reset (reset),
      .io    (bus)
   );

   always #5 clock = ~clock;

   localparam logic [6:0] SEG_0 = 7'b1000000;
   localparam logic [6:0] SEG_1 = 7'b1111001;
   localparam logic [6:0] SEG_2 = 7'b0100100;
   localparam logic [6:0] SEG_3 = 7'b0110000;
   localparam logic [6:0] SEG_A = 7'b0001000;
   localparam logic [6:0] SEG_D = 7'b0100001;
   localparam logic [6:0] SEG_E = 7'b0000110;

   int n_total = 0;
   int n_bad   = 0;
   logic [3:0] seq [4];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic press(input logic [3:0] b, input int hold = 2);
      bus.botoes = b;
      tick(hold);
      bus.botoes = 4'b0000;
      tick(3);
   endtask

   task automatic start(input logic [1:0] cfg);
      bus.configuracao = cfg;
      bus.jogar = 1'b1;
      tick(1);
      bus.jogar = 1'b0;
      tick(5);
      chk("leds_exibe", bus.leds, 3'b100);
      tick(2095);
      chk("estado_espera", bus.db_estado, SEG_3);
      chk("leds_off", bus.leds, 3'b000);
   endtask

   // Round r replays seq[0..r-1] then appends seq[r]; r=4 is the final replay only.
   task automatic round(input int r);
      for (int i = 0; i < r; i++) press(seq[i]);
      if (r < 4) press(seq[r]);
   endtask

   initial begin
      reset = 1'b1;
      bus.jogar = 1'b0;
      bus.botoes = 4'b0000;
      bus.configuracao = 2'b00;
      tick(2);
      chk("rst_ganhou", bus.ganhou, 1'b0);
      chk("rst_perdeu", bus.perdeu, 1'b0);
      chk("rst_pronto", bus.pronto, 1'b0);
      chk("rst_timeout", bus.timeout, 1'b0);
      chk("rst_leds", bus.leds, 3'b000);
      chk("rst_estado", bus.db_estado, SEG_0);
      chk("rst_contagem", bus.db_contagem, SEG_0);
      chk("rst_jogada", bus.db_jogadafeita, SEG_0);
      chk("rst_memoria", bus.db_memoria, SEG_1);
      reset = 1'b0;
      tick(3);
      chk("idle_estado", bus.db_estado, SEG_0);

      // Demo game, first play held long to exercise edge detection
      seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100; seq[3] = 4'b1000;
      start(2'b01);
      press(seq[0], 20);
      press(seq[1]);
      chk("r1_estado", bus.db_estado, SEG_3);
      chk("r1_contagem", bus.db_contagem, SEG_0);
      chk("r1_jogada", bus.db_jogadafeita, SEG_2);
      chk("r1_memoria", bus.db_memoria, SEG_1);
      round(2);
      round(3);
      round(4);
      chk("g1_ganhou", bus.ganhou, 1'b1);
      chk("g1_pronto", bus.pronto, 1'b1);
      chk("g1_perdeu", bus.perdeu, 1'b0);
      chk("g1_estado", bus.db_estado, SEG_A);

      // Configuration change mid-game must be ignored
      start(2'b01);
      round(1);
      press(seq[0]);
      bus.configuracao = 2'b00;
      press(seq[1]);
      press(seq[2]);
      round(3);
      round(4);
      chk("g2_ganhou", bus.ganhou, 1'b1);
      chk("g2_pronto", bus.pronto, 1'b1);

      // Demo with timeout enabled, repeated buttons
      seq[0] = 4'b0001; seq[1] = 4'b0001; seq[2] = 4'b0010; seq[3] = 4'b0010;
      start(2'b11);
      for (int r = 1; r <= 4; r++) round(r);
      chk("g3_ganhou", bus.ganhou, 1'b1);
      chk("g3_timeout", bus.timeout, 1'b0);

      // Wrong button in round 1
      start(2'b01);
      press(4'b0100);
      chk("g4_perdeu", bus.perdeu, 1'b1);
      chk("g4_ganhou", bus.ganhou, 1'b0);
      chk("g4_pronto", bus.pronto, 1'b1);
      chk("g4_estado", bus.db_estado, SEG_E);

      // Timeout: espera entered 2001 clocks after the start edge
      start(2'b11);
      tick(4880);
      chk("g5_pre_estado", bus.db_estado, SEG_3);
      chk("g5_pre_perdeu", bus.perdeu, 1'b0);
      tick(40);
      chk("g5_perdeu", bus.perdeu, 1'b1);
      chk("g5_timeout", bus.timeout, 1'b1);
      chk("g5_pronto", bus.pronto, 1'b1);
      chk("g5_estado", bus.db_estado, SEG_D);

      // Timeout disabled: long idle changes nothing
      start(2'b01);
      tick(6000);
      chk("g6_estado", bus.db_estado, SEG_3);
      chk("g6_perdeu", bus.perdeu, 1'b0);
      chk("g6_timeout", bus.timeout, 1'b0);
      chk("g6_pronto", bus.pronto, 1'b0);

      // Asynchronous reset mid-game
      #2;
      reset = 1'b1;
      #1;
      chk("arst_estado", bus.db_estado, SEG_0);
      tick(1);
      reset = 1'b0;
      tick(2);
      chk("arst_idle", bus.db_estado, SEG_0);

      // Two buttons at once mismatch the one-hot word
      start(2'b01);
      press(4'b0011);
      chk("g7_perdeu", bus.perdeu, 1'b1);
      chk("g7_ganhou", bus.ganhou, 1'b0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
